// File: rtl/alu_in_arb_pkg.sv
// Shared types and defaults for the multi-channel ALU_in round-robin arbiter.
package alu_in_arb_pkg;

    localparam int unsigned OP_W               = 3;
    localparam int unsigned ALU_RST_CYCLES_DEF = 2;

    typedef logic [OP_W-1:0] alu_op_t;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_in_ch_fifo.sv
// Per-channel beat buffer: {op, a, b} FIFO with synchronous clear.
// Occupancy flags decode straight from the registered count.
module alu_in_ch_fifo
    import alu_in_arb_pkg::*;
#(
    parameter  int unsigned OP_WIDTH = 8,
    parameter  int unsigned IN_DEPTH = 2,
    localparam int unsigned DATA_W   = OP_W + 2 * OP_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              empty_c,
    output logic              full_c
);

    localparam int unsigned PTR_W = $clog2(IN_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [IN_DEPTH];
    logic [DATA_W-1:0] mem_d [IN_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Next-state for storage, pointers (natural power-of-2 wrap) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign empty_c   = (count_q == '0);
    assign full_c    = (count_q == CNT_W'(IN_DEPTH));

endmodule

// File: rtl/alu_in_rr_arbiter.sv
// Multi-channel ALU_in front end: per-channel buffers, round-robin issue onto
// one registered output bus with channel tag, and ALU soft-reset generation.
// Optional per-channel grant counters: define ALU_IN_RR_ARB_STATS_EN.
module alu_in_rr_arbiter
    import alu_in_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH         = 4,
    parameter  int unsigned OP_WIDTH       = 8,
    parameter  int unsigned IN_DEPTH       = 2,
    parameter  int unsigned ALU_RST_CYCLES = ALU_RST_CYCLES_DEF,
    localparam int unsigned CH_ID_W        = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_CH-1:0]            ch_valid,
    output logic [NUM_CH-1:0]            ch_ready,
    input  logic [NUM_CH*OP_W-1:0]       ch_op,
    input  logic [NUM_CH*OP_WIDTH-1:0]   ch_a,
    input  logic [NUM_CH*OP_WIDTH-1:0]   ch_b,
    output logic                         alu_rst,
    output logic                         valid,
    input  logic                         ready,
    output logic [OP_W-1:0]              op,
    output logic [OP_WIDTH-1:0]          a,
    output logic [OP_WIDTH-1:0]          b,
    output logic [CH_ID_W-1:0]           ch_id
`ifdef ALU_IN_RR_ARB_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]         grant_cnt
`endif
);

    localparam int unsigned DATA_W = OP_W + 2 * OP_WIDTH;
    localparam int unsigned HCNT_W = $clog2(ALU_RST_CYCLES) + 1;

    arb_state_e            state_q, state_d;
    logic [HCNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  alu_rst_q, alu_rst_d;
    logic                  run;
    logic                  load;

    logic [NUM_CH-1:0]     push, pop, empty_c, full_c;
    logic [DATA_W-1:0]     rd_data_c [NUM_CH];

    logic                  grant_vld_c;
    logic [CH_ID_W-1:0]    grant_idx_c;
    logic [CH_ID_W-1:0]    cand_c;

    logic                  valid_q, valid_d;
    alu_op_t               op_q, op_d;
    logic [OP_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CH_ID_W-1:0]    ch_id_q, ch_id_d;
    logic [CH_ID_W-1:0]    rr_q, rr_d;

    assign run  = (state_q == RUN);
    assign load = run && !flush && (!valid_q || ready);

    // Channel buffers; beats offered during a flush cycle are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push[i] = ch_valid[i] && ch_ready[i] && !flush;
        assign pop[i]  = load && grant_vld_c && (grant_idx_c == CH_ID_W'(i));

        alu_in_ch_fifo #(
            .OP_WIDTH (OP_WIDTH),
            .IN_DEPTH (IN_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst),
            .clr       (flush),
            .push      (push[i]),
            .pop       (pop[i]),
            .din       ({ch_op[OP_W*i +: OP_W], ch_a[OP_WIDTH*i +: OP_WIDTH],
                         ch_b[OP_WIDTH*i +: OP_WIDTH]}),
            .rd_data_c (rd_data_c[i]),
            .empty_c   (empty_c[i]),
            .full_c    (full_c[i])
        );
    end

    assign ch_ready = run ? ~full_c : '0;

    // HOLD/RUN next-state; alu_rst tracks the next state so it is a flop output.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            HOLD: begin
                if (flush) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HCNT_W'(ALU_RST_CYCLES - 1)) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCNT_W'(1);
                end
            end
            RUN: begin
                if (flush) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
        endcase
        alu_rst_d = (state_d == HOLD);
    end

    // Round-robin pick: first non-empty channel strictly after rr_q, wrapping.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = rr_q;
        cand_c      = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand_c = CH_ID_W'((32'(rr_q) + k) % NUM_CH);
            if (!grant_vld_c && !empty_c[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
    end

    // Output stage and rr pointer; held while valid && !ready.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        ch_id_d = ch_id_q;
        rr_d    = rr_q;
        if (flush) begin
            valid_d = 1'b0;
            op_d    = '0;
            a_d     = '0;
            b_d     = '0;
            ch_id_d = '0;
            rr_d    = CH_ID_W'(NUM_CH - 1);
        end else if (load) begin
            if (grant_vld_c) begin
                valid_d           = 1'b1;
                {op_d, a_d, b_d}  = rd_data_c[grant_idx_c];
                ch_id_d           = grant_idx_c;
                rr_d              = grant_idx_c;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            alu_rst_q  <= 1'b1;
            valid_q    <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ch_id_q    <= '0;
            rr_q       <= CH_ID_W'(NUM_CH - 1);
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            alu_rst_q  <= alu_rst_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ch_id_q    <= ch_id_d;
            rr_q       <= rr_d;
        end
    end

    assign alu_rst = alu_rst_q;
    assign valid   = valid_q;
    assign op      = op_q;
    assign a       = a_q;
    assign b       = b_q;
    assign ch_id   = ch_id_q;

`ifdef ALU_IN_RR_ARB_STATS_EN
    // Saturating per-channel grant counters, cleared by flush.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_stats
        logic [15:0] gcnt_q, gcnt_d;

        always_comb begin
            gcnt_d = gcnt_q;
            if (flush) begin
                gcnt_d = '0;
            end else if (pop[i] && (gcnt_q != 16'hFFFF)) begin
                gcnt_d = gcnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                gcnt_q <= '0;
            end else begin
                gcnt_q <= gcnt_d;
            end
        end

        assign grant_cnt[16*i +: 16] = gcnt_q;
    end
`endif

endmodule

// File: tb/tb_alu_in_rr_arbiter.sv
// Bench for alu_in_rr_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_alu_in_rr_arbiter;

    localparam int NUM_CH = 4;
    localparam int OPW    = 8;
    localparam int DEPTH  = 2;
    localparam int RSTC   = 2;
    localparam int IDW    = 2;

    typedef struct {
        logic [2:0]     op;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0]       ch_ready;
    logic [NUM_CH*3-1:0]     ch_op;
    logic [NUM_CH*OPW-1:0]   ch_a;
    logic [NUM_CH*OPW-1:0]   ch_b;
    logic                    alu_rst;
    logic                    valid;
    logic                    ready;
    logic [2:0]              op;
    logic [OPW-1:0]          a;
    logic [OPW-1:0]          b;
    logic [IDW-1:0]          ch_id;
`ifdef ALU_IN_RR_ARB_STATS_EN
    logic [NUM_CH*16-1:0]    grant_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model state
    beat_t          m_q [NUM_CH][$];
    int             m_hold;
    int             m_last;
    bit             m_valid;
    logic [2:0]     m_op;
    logic [OPW-1:0] m_a, m_b;
    int             m_id;
    int             m_gcnt [NUM_CH];

    alu_in_rr_arbiter #(
        .NUM_CH         (NUM_CH),
        .OP_WIDTH       (OPW),
        .IN_DEPTH       (DEPTH),
        .ALU_RST_CYCLES (RSTC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ch_valid (ch_valid),
        .ch_ready (ch_ready),
        .ch_op    (ch_op),
        .ch_a     (ch_a),
        .ch_b     (ch_b),
        .alu_rst  (alu_rst),
        .valid    (valid),
        .ready    (ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .ch_id    (ch_id)
`ifdef ALU_IN_RR_ARB_STATS_EN
        ,
        .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_q[i].delete();
            m_gcnt[i] = 0;
        end
        m_hold  = RSTC;
        m_last  = NUM_CH - 1;
        m_valid = 0;
        m_op    = '0;
        m_a     = '0;
        m_b     = '0;
        m_id    = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit    acc [NUM_CH];
        int    g;
        int    c;
        beat_t bt;
        if (m_hold != 0) begin
            if (flush) begin
                m_hold = RSTC;
                for (int i = 0; i < NUM_CH; i++) m_gcnt[i] = 0;
            end else begin
                m_hold = m_hold - 1;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_q[i].delete();
                m_gcnt[i] = 0;
            end
            m_valid = 0;
            m_op    = '0;
            m_a     = '0;
            m_b     = '0;
            m_id    = 0;
            m_last  = NUM_CH - 1;
            m_hold  = RSTC;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                acc[i] = ch_valid[i] && (m_q[i].size() < DEPTH);
            if (!m_valid || ready) begin
                g = -1;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_last + k) % NUM_CH;
                    if (g < 0 && m_q[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    bt      = m_q[g].pop_front();
                    m_valid = 1;
                    m_op    = bt.op;
                    m_a     = bt.a;
                    m_b     = bt.b;
                    m_id    = g;
                    m_last  = g;
                    if (m_gcnt[g] < 65535) m_gcnt[g]++;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (acc[i]) begin
                    bt.op = ch_op[3*i +: 3];
                    bt.a  = ch_a[OPW*i +: OPW];
                    bt.b  = ch_b[OPW*i +: OPW];
                    m_q[i].push_back(bt);
                end
            end
        end
    endtask

    function automatic logic [NUM_CH-1:0] m_ready();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++)
            r[i] = (m_hold == 0) && (m_q[i].size() < DEPTH);
        return r;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        flush    = 1'b0;
        ready    = 1'b0;
        ch_valid = '0;
        ch_op    = '0;
        ch_a     = '0;
        ch_b     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic set_beat(input int ch, input logic [2:0] o,
                            input logic [OPW-1:0] av, input logic [OPW-1:0] bv);
        ch_op[3*ch +: 3]   = o;
        ch_a[OPW*ch +: OPW] = av;
        ch_b[OPW*ch +: OPW] = bv;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (alu_rst !== 1'b1) begin n_bad++; $display("FAIL reset_alu_rst got %b exp 1", alu_rst); end
        n_cmp++; if (valid !== 1'b0 || op !== 3'd0 || a !== 8'd0 || ch_id !== 2'd0) begin n_bad++; $display("FAIL reset_outputs got v=%b op=%0d a=%h id=%0d exp zeros", valid, op, a, ch_id); end
        n_cmp++; if (ch_ready !== 4'h0) begin n_bad++; $display("FAIL reset_ch_ready got %h exp 0", ch_ready); end
        step();
        n_cmp++; if (alu_rst !== 1'b1 || ch_ready !== 4'h0) begin n_bad++; $display("FAIL hold_cycle2 got alu_rst=%b ch_ready=%h exp 1/0", alu_rst, ch_ready); end
        step();
        n_cmp++; if (alu_rst !== 1'b0 || ch_ready !== 4'hF || valid !== 1'b0) begin n_bad++; $display("FAIL run_entry got alu_rst=%b ch_ready=%h valid=%b exp 0/F/0", alu_rst, ch_ready, valid); end
        n_cmp++; if (ch_ready !== m_ready()) begin n_bad++; $display("FAIL run_entry_model got %h exp %h", ch_ready, m_ready()); end
    endtask

    task automatic test_single_beat();
        do_reset();
        step(); step();
        ready = 1'b1;
        ch_valid = 4'b0100;
        set_beat(2, 3'd1, 8'h12, 8'h34);
        step();
        ch_valid = '0;
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_early got valid=%b exp 0", valid); end
        step();
        n_cmp++; if (valid !== 1'b1 || op !== 3'd1 || a !== 8'h12 || b !== 8'h34 || ch_id !== 2'd2) begin
            n_bad++; $display("FAIL single_beat got v=%b op=%0d a=%h b=%h id=%0d exp 1/1/12/34/2", valid, op, a, b, ch_id); end
        step();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got valid=%b exp 0", valid); end
    endtask

    task automatic test_fairness();
        do_reset();
        step(); step();
        ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            ch_valid = 4'hF;
            for (int c = 0; c < NUM_CH; c++)
                set_beat(c, 3'(c + j), 8'(16 * c + j), 8'(255 - 16 * c - j));
            step();
        end
        ch_valid = '0;
        for (int k = 0; k < 2 * NUM_CH; k++) begin
            n_cmp++; if (valid !== 1'b1 || ch_id !== IDW'(k % NUM_CH) || a !== 8'(16 * (k % NUM_CH) + k / NUM_CH)) begin
                n_bad++; $display("FAIL fair_seq%0d got v=%b id=%0d a=%h exp 1/%0d/%h", k, valid, ch_id, a, k % NUM_CH, 8'(16 * (k % NUM_CH) + k / NUM_CH)); end
            step();
        end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL fair_end got valid=%b exp 0", valid); end
    endtask

    task automatic test_backpressure();
        logic [OPW-1:0] av [3];
        av[0] = 8'hA1; av[1] = 8'hB2; av[2] = 8'hC3;
        do_reset();
        step(); step();
        ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            ch_valid = 4'b0010;
            set_beat(1, 3'(j + 4), av[j], ~av[j]);
            step();
        end
        ch_valid = '0;
        n_cmp++; if (ch_ready !== 4'b1101) begin n_bad++; $display("FAIL bp_full got ch_ready=%b exp 1101", ch_ready); end
        for (int s = 0; s < 5; s++) begin
            n_cmp++; if (valid !== 1'b1 || a !== av[0] || b !== ~av[0] || op !== 3'd4 || ch_id !== 2'd1) begin
                n_bad++; $display("FAIL bp_hold%0d got v=%b op=%0d a=%h b=%h id=%0d exp 1/4/%h/%h/1", s, valid, op, a, b, ch_id, av[0], ~av[0]); end
            step();
        end
        ready = 1'b1;
        for (int j = 1; j < 3; j++) begin
            step();
            n_cmp++; if (valid !== 1'b1 || a !== av[j] || op !== 3'(j + 4)) begin
                n_bad++; $display("FAIL bp_drain%0d got v=%b a=%h op=%0d exp 1/%h/%0d", j, valid, a, op, av[j], j + 4); end
        end
        step();
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty got valid=%b exp 0", valid); end
    endtask

    task automatic test_flush();
        do_reset();
        step(); step();
        ready = 1'b0;
        ch_valid = 4'hF;
        for (int c = 0; c < NUM_CH; c++) set_beat(c, 3'd2, 8'(8'h40 + c), 8'h00);
        step();
        ch_valid = '0;
        step();
        n_cmp++; if (valid !== 1'b1 || ch_id !== 2'd0) begin n_bad++; $display("FAIL flush_pre got v=%b id=%0d exp 1/0", valid, ch_id); end
        flush = 1'b1;
        ch_valid = 4'b0010;
        step();
        flush = 1'b0;
        ch_valid = '0;
        n_cmp++; if (valid !== 1'b0 || alu_rst !== 1'b1 || ch_ready !== 4'h0) begin
            n_bad++; $display("FAIL flush_next got v=%b alu_rst=%b ch_ready=%h exp 0/1/0", valid, alu_rst, ch_ready); end
        step();
        n_cmp++; if (alu_rst !== 1'b1) begin n_bad++; $display("FAIL flush_hold2 got alu_rst=%b exp 1", alu_rst); end
        step();
        n_cmp++; if (alu_rst !== 1'b0 || ch_ready !== 4'hF) begin n_bad++; $display("FAIL flush_run got alu_rst=%b ch_ready=%h exp 0/F", alu_rst, ch_ready); end
        ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale%0d got valid=%b exp 0", s, valid); end
        end
        ch_valid = 4'b1001;
        set_beat(0, 3'd3, 8'h5A, 8'h01);
        set_beat(3, 3'd6, 8'h6B, 8'h02);
        step();
        ch_valid = '0;
        step();
        n_cmp++; if (valid !== 1'b1 || ch_id !== 2'd0 || a !== 8'h5A) begin
            n_bad++; $display("FAIL flush_first_grant got v=%b id=%0d a=%h exp 1/0/5a", valid, ch_id, a); end
    endtask

    task automatic test_random();
        do_reset();
        step(); step();
        for (int n = 0; n < 600; n++) begin
            ch_valid = 4'($urandom);
            ch_op    = 12'($urandom);
            ch_a     = 32'($urandom);
            ch_b     = 32'($urandom);
            ready    = ($urandom_range(3) != 0);
            flush    = ($urandom_range(49) == 0);
            step();
            n_cmp++; if (valid !== m_valid || alu_rst !== (m_hold != 0) || ch_ready !== m_ready()) begin
                n_bad++; $display("FAIL rand_ctl cyc %0d got v=%b alu_rst=%b rdy=%h exp %b/%b/%h", cyc, valid, alu_rst, ch_ready, m_valid, m_hold != 0, m_ready()); end
            if (m_valid) begin
                n_cmp++; if (op !== m_op || a !== m_a || b !== m_b || ch_id !== IDW'(m_id)) begin
                    n_bad++; $display("FAIL rand_data cyc %0d got op=%0d a=%h b=%h id=%0d exp %0d/%h/%h/%0d", cyc, op, a, b, ch_id, m_op, m_a, m_b, m_id); end
            end
`ifdef ALU_IN_RR_ARB_STATS_EN
            for (int c = 0; c < NUM_CH; c++) begin
                n_cmp++; if (grant_cnt[16*c +: 16] !== 16'(m_gcnt[c])) begin
                    n_bad++; $display("FAIL rand_gcnt%0d got %0d exp %0d", c, grant_cnt[16*c +: 16], m_gcnt[c]); end
            end
`endif
        end
        flush = 1'b0;
    endtask

`ifdef ALU_IN_RR_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        step(); step();
        ready    = 1'b1;
        ch_valid = 4'b0001;
        set_beat(0, 3'd7, 8'h11, 8'h22);
        for (int n = 0; n < 70005; n++) step();
        ch_valid = '0;
        n_cmp++; if (grant_cnt[15:0] !== 16'hFFFF || m_gcnt[0] != 65535) begin
            n_bad++; $display("FAIL stats_sat got %h exp ffff (model %0d)", grant_cnt[15:0], m_gcnt[0]); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (grant_cnt !== '0) begin n_bad++; $display("FAIL stats_flush got %h exp 0", grant_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_fairness();
        test_backpressure();
        test_flush();
        test_random();
`ifdef ALU_IN_RR_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
